// File: rtl/result_queue_pkg.sv
// Shared definitions for the detection result queue: default geometry,
// the packed result-entry layout and small arithmetic helpers.
package pkg_resultQueue;

  localparam int DEPTH_DEF = 64;
  localparam int XW_DEF    = 10;
  localparam int YW_DEF    = 10;
  localparam int SW_DEF    = 16;
  localparam int PTR_W     = $clog2(DEPTH_DEF);
  localparam int ENTRY_W   = XW_DEF + YW_DEF + SW_DEF;

  // Entry as presented on rd_data: scale in the MSBs, x in the LSBs.
  typedef struct packed {
    logic [SW_DEF-1:0] scale;
    logic [YW_DEF-1:0] y;
    logic [XW_DEF-1:0] x;
  } result_entry_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/result_queue_ram.sv
// Simple dual-port storage for the result queue: one write port and one
// registered read port, written in a shape that maps onto block RAM.
module result_queue_ram #(
  parameter int DW = 36,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  // Array write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Output register holds its value between pops; only it sees reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_q <= {DW{1'b0}};
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/result_queue.sv
// FIFO of detection results {scale,y,x} between the result store and the
// host, with occupancy, sticky overflow and a saturating accepted-write count.
module result_queue
  import pkg_resultQueue::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int XW    = XW_DEF,
  parameter int YW    = YW_DEF,
  parameter int SW    = SW_DEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    wr_valid,
  input  logic [XW-1:0]           wr_x,
  input  logic [YW-1:0]           wr_y,
  input  logic [SW-1:0]           wr_scale,
  output logic                    wr_ready,
  input  logic                    clear,
  input  logic                    rd_en,
  output logic                    rd_valid,
  output logic [XW+YW+SW-1:0]     rd_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic [15:0]             total
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = XW + YW + SW;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   total_q, total_d;
  logic          overflow_q, overflow_d;
  logic          rd_valid_q, rd_valid_d;
  logic          wr_acc_s, rd_acc_s;

  assign wr_ready = (count_q != FULL_CNT);

  // Acceptance uses the pre-cycle count, so an empty queue never forwards
  // a same-cycle write to a pop; clear suppresses both sides.
  always_comb begin
    wr_acc_s   = wr_valid && wr_ready && !clear;
    rd_acc_s   = rd_en && (count_q != {CW{1'b0}}) && !clear;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    total_d    = total_q;
    overflow_d = overflow_q;
    rd_valid_d = 1'b0;
    if (clear) begin
      wptr_d     = {AW{1'b0}};
      rptr_d     = {AW{1'b0}};
      count_d    = {CW{1'b0}};
      total_d    = 16'd0;
      overflow_d = 1'b0;
    end else begin
      if (wr_acc_s) begin
        wptr_d  = wptr_q + PTR_ONE;
        total_d = sat_inc16(total_q);
      end else begin
        wptr_d  = wptr_q;
      end
      if (rd_acc_s) begin
        rptr_d = rptr_q + PTR_ONE;
      end else begin
        rptr_d = rptr_q;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      overflow_d = overflow_q | (wr_valid && !wr_ready);
      rd_valid_d = rd_acc_s;
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q     <= {AW{1'b0}};
      rptr_q     <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      total_q    <= 16'd0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      total_q    <= total_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  result_queue_ram #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clk   (clk),
    .resetn(resetn),
    .we    (wr_acc_s),
    .waddr (wptr_q),
    .wdata ({wr_scale, wr_y, wr_x}),
    .re    (rd_acc_s),
    .raddr (rptr_q),
    .rdata (rd_data)
  );

  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign total    = total_q;

endmodule

// File: tb/tb_result_queue.sv
// Directed bench for result_queue: a cycle-by-cycle vector table plus
// hand-written sequences for fill/overflow, wrap, clear and reset corners.
module tb_result_queue;
  import pkg_resultQueue::*;

  logic        clk;
  logic        resetn;
  logic        wr_valid;
  logic [9:0]  wr_x;
  logic [9:0]  wr_y;
  logic [15:0] wr_scale;
  logic        wr_ready;
  logic        clear;
  logic        rd_en;
  logic        rd_valid;
  logic [35:0] rd_data;
  logic [6:0]  count;
  logic        overflow;
  logic [15:0] total;

  int errors = 0;
  int checks = 0;

  result_queue dut (
    .clk     (clk),
    .resetn  (resetn),
    .wr_valid(wr_valid),
    .wr_x    (wr_x),
    .wr_y    (wr_y),
    .wr_scale(wr_scale),
    .wr_ready(wr_ready),
    .clear   (clear),
    .rd_en   (rd_en),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .count   (count),
    .overflow(overflow),
    .total   (total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wv;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] s;
    logic        re;
    logic        clr;
    logic        erv;
    logic [35:0] edata;
    logic [6:0]  ecnt;
    logic [15:0] etot;
    logic        eovf;
    logic        ewr;
  } vec_t;

  vec_t vt [6];
  logic [35:0] sb [$];

  function automatic logic [35:0] ent(input logic [9:0] x, input logic [9:0] y,
                                      input logic [15:0] s);
    result_entry_t e;
    e.scale = s;
    e.y     = y;
    e.x     = x;
    return e;
  endfunction

  function automatic vec_t mk(input logic wv, input logic [9:0] x, input logic [9:0] y,
                              input logic [15:0] s, input logic re, input logic clr,
                              input logic erv, input logic [35:0] edata,
                              input logic [6:0] ecnt, input logic [15:0] etot,
                              input logic eovf, input logic ewr);
    vec_t v;
    v.wv = wv; v.x = x; v.y = y; v.s = s; v.re = re; v.clr = clr;
    v.erv = erv; v.edata = edata; v.ecnt = ecnt; v.etot = etot;
    v.eovf = eovf; v.ewr = ewr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wv, input logic [9:0] x, input logic [9:0] y,
                       input logic [15:0] s, input logic re, input logic clr);
    wr_valid = wv; wr_x = x; wr_y = y; wr_scale = s; rd_en = re; clear = clr;
  endtask

  task automatic do_reset();
    drive(1'b0, 10'd0, 10'd0, 16'd0, 1'b0, 1'b0);
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    drive(1'b0, 10'd0, 10'd0, 16'd0, 1'b0, 1'b0);
    tick();
    tick();
    chk("reset_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("reset_rd_data",  {28'd0, rd_data}, 64'd0);
    chk("reset_count",    {57'd0, count}, 64'd0);
    chk("reset_overflow", {63'd0, overflow}, 64'd0);
    chk("reset_total",    {48'd0, total}, 64'd0);
    chk("reset_wr_ready", {63'd0, wr_ready}, 64'd1);
    resetn = 1'b1;

    // Basic pop latency, hold on idle, empty-with-write, rejected pop.
    vt[0] = mk(1'b1, 10'd5, 10'd7, 16'd24, 1'b0, 1'b0, 1'b0, 36'd0,                   7'd1, 16'd1, 1'b0, 1'b1);
    vt[1] = mk(1'b0, 10'd0, 10'd0, 16'd0,  1'b1, 1'b0, 1'b1, 36'h00180_1C05,         7'd0, 16'd1, 1'b0, 1'b1);
    vt[2] = mk(1'b0, 10'd0, 10'd0, 16'd0,  1'b0, 1'b0, 1'b0, 36'h00180_1C05,         7'd0, 16'd1, 1'b0, 1'b1);
    vt[3] = mk(1'b1, 10'd1, 10'd2, 16'd3,  1'b1, 1'b0, 1'b0, 36'h00180_1C05,         7'd1, 16'd2, 1'b0, 1'b1);
    vt[4] = mk(1'b0, 10'd0, 10'd0, 16'd0,  1'b1, 1'b0, 1'b1, 36'h00030_0801,         7'd0, 16'd2, 1'b0, 1'b1);
    vt[5] = mk(1'b0, 10'd0, 10'd0, 16'd0,  1'b1, 1'b0, 1'b0, 36'h00030_0801,         7'd0, 16'd2, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      drive(vt[i].wv, vt[i].x, vt[i].y, vt[i].s, vt[i].re, vt[i].clr);
      tick();
      chk($sformatf("vec%0d_rd_valid", i), {63'd0, rd_valid}, {63'd0, vt[i].erv});
      chk($sformatf("vec%0d_rd_data", i),  {28'd0, rd_data},  {28'd0, vt[i].edata});
      chk($sformatf("vec%0d_count", i),    {57'd0, count},    {57'd0, vt[i].ecnt});
      chk($sformatf("vec%0d_total", i),    {48'd0, total},    {48'd0, vt[i].etot});
      chk($sformatf("vec%0d_overflow", i), {63'd0, overflow}, {63'd0, vt[i].eovf});
      chk($sformatf("vec%0d_wr_ready", i), {63'd0, wr_ready}, {63'd0, vt[i].ewr});
    end

    // Reset arriving with a pop pending aborts it.
    drive(1'b1, 10'd11, 10'd12, 16'd13, 1'b0, 1'b0);
    tick();
    drive(1'b0, 10'd0, 10'd0, 16'd0, 1'b1, 1'b0);
    resetn = 1'b0;
    tick();
    chk("midrst_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("midrst_rd_data",  {28'd0, rd_data}, 64'd0);
    chk("midrst_count",    {57'd0, count}, 64'd0);
    resetn = 1'b1;
    drive(1'b0, 10'd0, 10'd0, 16'd0, 1'b0, 1'b0);

    // Fill to 64, then one more write, then write+pop while full.
    do_reset();
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 10'(i), 10'(i + 100), 16'(i * 3), 1'b0, 1'b0);
      tick();
    end
    chk("full_count",    {57'd0, count}, 64'd64);
    chk("full_wr_ready", {63'd0, wr_ready}, 64'd0);
    chk("full_overflow", {63'd0, overflow}, 64'd0);
    chk("full_total",    {48'd0, total}, 64'd64);
    drive(1'b1, 10'd999, 10'd999, 16'd999, 1'b0, 1'b0);
    tick();
    chk("ovf_overflow", {63'd0, overflow}, 64'd1);
    chk("ovf_total",    {48'd0, total}, 64'd64);
    chk("ovf_count",    {57'd0, count}, 64'd64);
    drive(1'b1, 10'd998, 10'd998, 16'd998, 1'b1, 1'b0);
    tick();
    chk("fullpop_rd_valid", {63'd0, rd_valid}, 64'd1);
    chk("fullpop_rd_data",  {28'd0, rd_data}, {28'd0, ent(10'd0, 10'd100, 16'd0)});
    chk("fullpop_count",    {57'd0, count}, 64'd63);
    chk("fullpop_overflow", {63'd0, overflow}, 64'd1);
    chk("fullpop_total",    {48'd0, total}, 64'd64);

    // Clear drops the sticky overflow and counters.
    drive(1'b0, 10'd0, 10'd0, 16'd0, 1'b0, 1'b1);
    tick();
    chk("clr1_count",    {57'd0, count}, 64'd0);
    chk("clr1_overflow", {63'd0, overflow}, 64'd0);
    chk("clr1_total",    {48'd0, total}, 64'd0);

    // Ten entries, then clear with a same-cycle pop and write.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 10'(i + 40), 10'd1, 16'd1, 1'b0, 1'b0);
      tick();
    end
    chk("pre_clr_count", {57'd0, count}, 64'd10);
    drive(1'b1, 10'd77, 10'd77, 16'd77, 1'b1, 1'b1);
    tick();
    chk("clr2_count",    {57'd0, count}, 64'd0);
    chk("clr2_total",    {48'd0, total}, 64'd0);
    chk("clr2_overflow", {63'd0, overflow}, 64'd0);
    chk("clr2_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("clr2_wr_ready", {63'd0, wr_ready}, 64'd1);
    drive(1'b1, 10'd9, 10'd8, 16'd7, 1'b0, 1'b0);
    tick();
    drive(1'b0, 10'd0, 10'd0, 16'd0, 1'b1, 1'b0);
    tick();
    chk("postclr_rd_valid", {63'd0, rd_valid}, 64'd1);
    chk("postclr_rd_data",  {28'd0, rd_data}, {28'd0, ent(10'd9, 10'd8, 16'd7)});

    // 200 writes interleaved with pops across several pointer wraps.
    do_reset();
    sb.delete();
    drive(1'b1, 10'd0, 10'd0, 16'hA5A5, 1'b0, 1'b0);
    sb.push_back(ent(10'd0, 10'd0, 16'hA5A5));
    tick();
    for (int k = 1; k < 200; k++) begin
      logic [35:0] exp_e;
      drive(1'b1, 10'(k), 10'(k * 7), 16'(k) ^ 16'hA5A5, 1'b1, 1'b0);
      sb.push_back(ent(10'(k), 10'(k * 7), 16'(k) ^ 16'hA5A5));
      tick();
      exp_e = sb.pop_front();
      chk($sformatf("wrap%0d_rd_valid", k), {63'd0, rd_valid}, 64'd1);
      chk($sformatf("wrap%0d_rd_data", k),  {28'd0, rd_data}, {28'd0, exp_e});
    end
    drive(1'b0, 10'd0, 10'd0, 16'd0, 1'b1, 1'b0);
    tick();
    chk("wrap_last_rd_valid", {63'd0, rd_valid}, 64'd1);
    chk("wrap_last_rd_data",  {28'd0, rd_data}, {28'd0, sb.pop_front()});
    chk("wrap_total",         {48'd0, total}, 64'd200);
    chk("wrap_count",         {57'd0, count}, 64'd0);
    drive(1'b0, 10'd0, 10'd0, 16'd0, 1'b0, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
